// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake, synchronous flush and
// an optional 2-entry skid buffer that keeps in_ready_o off any combinational path.
module pipe_skid_reg #(
  parameter int                 DATA_W  = 107,
  parameter bit                 SKID_EN = 1'b1,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occ_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  generate
    if (SKID_EN) begin : g_skid
      state_e              state_q, state_d;
      logic [DATA_W-1:0]   main_q, main_d;
      logic [DATA_W-1:0]   skid_q, skid_d;
      logic                in_ready_q, in_ready_d;
      logic                in_fire, out_fire;

      assign in_fire  = in_valid_i & in_ready_q;
      assign out_fire = (state_q != EMPTY) & out_ready_i;

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
          EMPTY: begin
            if (in_fire) begin
              state_d = ONE;
              main_d  = in_data_i;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              main_d = in_data_i;
            end else if (in_fire) begin
              state_d = FULL;
              skid_d  = in_data_i;
            end else if (out_fire) begin
              state_d = EMPTY;
            end
          end
          FULL: begin
            if (out_fire) begin
              state_d = ONE;
              main_d  = skid_q;
            end
          end
          default: state_d = EMPTY;
        endcase
        // Flush discards both held entries and anything offered this cycle.
        if (flush_i) begin
          state_d = EMPTY;
          main_d  = RST_VAL;
          skid_d  = RST_VAL;
        end
        in_ready_d = (state_d != FULL);
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          state_q    <= EMPTY;
          main_q     <= RST_VAL;
          skid_q     <= RST_VAL;
          in_ready_q <= 1'b0;
        end else begin
          state_q    <= state_d;
          main_q     <= main_d;
          skid_q     <= skid_d;
          in_ready_q <= in_ready_d;
        end
      end

      assign in_ready_o  = in_ready_q;
      assign out_valid_o = (state_q != EMPTY);
      assign out_data_o  = main_q;
      assign occ_o       = state_q;
    end else begin : g_single
      logic                valid_q, valid_d;
      logic [DATA_W-1:0]   main_q, main_d;
      logic                live_q;
      logic                in_ready;
      logic                in_fire, out_fire;

      // live_q keeps in_ready low until the first edge after reset release.
      assign in_ready = live_q & (~valid_q | out_ready_i);
      assign in_fire  = in_valid_i & in_ready;
      assign out_fire = valid_q & out_ready_i;

      always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        if (in_fire) begin
          valid_d = 1'b1;
          main_d  = in_data_i;
        end else if (out_fire) begin
          valid_d = 1'b0;
        end
        if (flush_i) begin
          valid_d = 1'b0;
          main_d  = RST_VAL;
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          valid_q <= 1'b0;
          main_q  <= RST_VAL;
          live_q  <= 1'b0;
        end else begin
          valid_q <= valid_d;
          main_q  <= main_d;
          live_q  <= 1'b1;
        end
      end

      assign in_ready_o  = in_ready;
      assign out_valid_o = valid_q;
      assign out_data_o  = main_q;
      assign occ_o       = {1'b0, valid_q};
    end
  endgenerate

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomized checks of pipe_skid_reg in both skid and single-register builds.
module tb_pipe_skid_reg;
  localparam int DATA_W = 107;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              flush, in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0]        occ;

  logic              s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
  logic [DATA_W-1:0] s0_in_data, s0_out_data;
  logic [1:0]        s0_occ;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_skid_reg #(.DATA_W(DATA_W), .SKID_EN(1'b1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .occ_o(occ)
  );

  pipe_skid_reg #(.DATA_W(DATA_W), .SKID_EN(1'b0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(s0_flush),
    .in_valid_i(s0_in_valid), .in_ready_o(s0_in_ready), .in_data_i(s0_in_data),
    .out_valid_o(s0_out_valid), .out_ready_i(s0_out_ready), .out_data_o(s0_out_data),
    .occ_o(s0_occ)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_occ(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_data(input string tag, input logic [DATA_W-1:0] obs,
                            input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] q0[$];
  logic [127:0]      r;
  logic              fi, fo, fi0, fo0;

  initial begin
    flush = 1'b0; in_valid = 1'b1; in_data = 107'hAA; out_ready = 1'b1;
    s0_flush = 1'b0; s0_in_valid = 1'b1; s0_in_data = 107'hAA; s0_out_ready = 1'b1;

    // Reset with a valid offer present
    tick(); tick();
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_occ("rst_occ", occ, 2'd0);
    check_bit("rst_in_ready", in_ready, 1'b0);
    check_data("rst_out_data", out_data, '0);
    check_bit("rst_s0_in_ready", s0_in_ready, 1'b0);
    check_bit("rst_s0_out_valid", s0_out_valid, 1'b0);
    rst_n = 1'b1; in_valid = 1'b0; s0_in_valid = 1'b0;
    #1;
    check_bit("rel_in_ready_pre", in_ready, 1'b0);
    tick();
    check_bit("rel_in_ready_post", in_ready, 1'b1);
    check_bit("rel_s0_in_ready_post", s0_in_ready, 1'b1);
    check_bit("rel_out_valid", out_valid, 1'b0);

    // Back-to-back stream, 1-cycle latency
    in_valid = 1'b1; in_data = 107'h1;
    tick();
    check_bit("str1_valid", out_valid, 1'b1);
    check_data("str1_data", out_data, 107'h1);
    check_occ("str1_occ", occ, 2'd1);
    in_data = 107'h2;
    tick();
    check_data("str2_data", out_data, 107'h2);
    check_occ("str2_occ", occ, 2'd1);
    in_data = 107'h3;
    tick();
    check_data("str3_data", out_data, 107'h3);
    check_occ("str3_occ", occ, 2'd1);
    in_valid = 1'b0;
    tick();
    check_bit("str_drain_valid", out_valid, 1'b0);
    check_occ("str_drain_occ", occ, 2'd0);

    // Stall fills the skid buffer, then drains in order
    out_ready = 1'b0; in_valid = 1'b1; in_data = 107'h10;
    tick();
    check_occ("stl1_occ", occ, 2'd1);
    in_data = 107'h11;
    tick();
    check_occ("stl2_occ", occ, 2'd2);
    check_bit("stl2_in_ready", in_ready, 1'b0);
    check_data("stl2_data", out_data, 107'h10);
    in_data = 107'h12;
    tick();
    check_occ("stl3_occ", occ, 2'd2);
    check_data("stl3_hold", out_data, 107'h10);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check_data("stl_first_out", out_data, 107'h10);
    tick();
    check_data("stl_second_out", out_data, 107'h11);
    check_occ("stl_occ_one", occ, 2'd1);
    check_bit("stl_in_ready_back", in_ready, 1'b1);
    tick();
    check_bit("stl_empty_valid", out_valid, 1'b0);

    // Flush at occ=2 with an incoming offer
    out_ready = 1'b0; in_valid = 1'b1; in_data = 107'h20;
    tick();
    in_data = 107'h21;
    tick();
    check_occ("fl_pre_occ", occ, 2'd2);
    flush = 1'b1; in_data = 107'h55;
    tick();
    check_bit("fl_valid", out_valid, 1'b0);
    check_occ("fl_occ", occ, 2'd0);
    check_data("fl_data", out_data, '0);
    check_bit("fl_in_ready", in_ready, 1'b1);
    // Flush at occ=0 with a firing offer discards it
    tick();
    check_occ("fl0_occ", occ, 2'd0);
    check_bit("fl0_valid", out_valid, 1'b0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check_bit("fl_post_valid", out_valid, 1'b0);
    check_occ("fl_post_occ", occ, 2'd0);

    // Single-register build: combinational ready and pass-through
    s0_out_ready = 1'b0; s0_in_valid = 1'b1; s0_in_data = 107'h30;
    tick();
    check_bit("s0_valid", s0_out_valid, 1'b1);
    check_data("s0_data", s0_out_data, 107'h30);
    check_occ("s0_occ", s0_occ, 2'd1);
    check_bit("s0_stall_ready", s0_in_ready, 1'b0);
    s0_out_ready = 1'b1; s0_in_data = 107'h31;
    #1;
    check_bit("s0_comb_ready", s0_in_ready, 1'b1);
    tick();
    check_data("s0_pt1", s0_out_data, 107'h31);
    s0_in_data = 107'h32;
    tick();
    check_data("s0_pt2", s0_out_data, 107'h32);
    check_occ("s0_pt2_occ", s0_occ, 2'd1);
    s0_in_valid = 1'b0;
    tick();
    check_bit("s0_drain_valid", s0_out_valid, 1'b0);

    // Random handshake traffic on both builds against a queue model
    for (int cyc = 0; cyc < 10000; cyc++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_data   = r[DATA_W-1:0];
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 99) == 0);
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      s0_in_data   = r[DATA_W-1:0];
      s0_in_valid  = 1'($urandom_range(0, 1));
      s0_out_ready = 1'($urandom_range(0, 1));
      s0_flush     = ($urandom_range(0, 99) == 0);
      #1;
      check_occ("rnd_occ", occ, 2'(q.size()));
      check_bit("rnd_occ_le2", occ <= 2'd2, 1'b1);
      check_bit("rnd_valid", out_valid, q.size() != 0);
      check_bit("rnd_in_ready", in_ready, q.size() != 2);
      if (q.size() != 0) check_data("rnd_data", out_data, q[0]);
      check_occ("rnd_s0_occ", s0_occ, 2'(q0.size()));
      check_bit("rnd_s0_in_ready", s0_in_ready, (q0.size() == 0) || s0_out_ready);
      if (q0.size() != 0) check_data("rnd_s0_data", s0_out_data, q0[0]);

      fi = in_valid & in_ready;
      fo = out_valid & out_ready;
      if (fo && q.size() != 0) void'(q.pop_front());
      if (flush) q.delete();
      else if (fi) q.push_back(in_data);
      fi0 = s0_in_valid & s0_in_ready;
      fo0 = s0_out_valid & s0_out_ready;
      if (fo0 && q0.size() != 0) void'(q0.pop_front());
      if (s0_flush) q0.delete();
      else if (fi0) q0.push_back(s0_in_data);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
